procesor_mc: RTL

Parametrised multi-cycle accumulator processor. It is the next generation of the top-level `procesor` core exercised by the CPU bench.
- Generalised data width, program depth and register count.
- Adds a loadable program memory, a FETCH/DECODE/EXEC state machine, flags, conditional jumps, an output port and a halt state.
- Sits at the top of the design; the bench drives the clock, loads the program and starts execution.

---
 rtl/procesor_mc.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/procesor_mc.sv
`default_nettype none
// ============================================================================
// Module      : procesor_mc
// Description : Parametrised multi-cycle accumulator processor. A loadable
//               program memory is written while the core is stopped. Each
//               instruction passes through FETCH, DECODE and EXEC, taking
//               exactly three cycles.
//               Instruction word layout: [opcode 4 | rsel RSEL_W | imm DATA_W]
// Ports       : clk, rst       - clock, synchronous active-high reset
//               start          - leave STOP and run from the current pc
//               prog_we/addr/data - program memory write, honoured in STOP only
//               out_data/out_valid - OUT port value and one-cycle update pulse
//               pc, acc        - program counter and accumulator
//               flag_z, flag_c - zero and carry/borrow flags
//               halted         - high while in STOP
//               step_mode, step - present only with PROCESOR_STEP_EN
// Options     : `define PROCESOR_STEP_EN adds single-step execution
// Revision    : 1.0 - initial release
// ============================================================================
module procesor_mc #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int NREG   = 4,
    localparam int RSEL_W  = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int INSTR_W = 4 + RSEL_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [DATA_W-1:0]  acc,
    output logic               flag_z,
    output logic               flag_c,
    output logic               halted
`ifdef PROCESOR_STEP_EN
    ,
    input  logic               step_mode,
    input  logic               step
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [RSEL_W:0] C_NREG = (RSEL_W + 1)'(NREG);

    localparam logic [3:0] C_OP_NOP = 4'h0;
    localparam logic [3:0] C_OP_LDI = 4'h1;
    localparam logic [3:0] C_OP_ADD = 4'h2;
    localparam logic [3:0] C_OP_SUB = 4'h3;
    localparam logic [3:0] C_OP_AND = 4'h4;
    localparam logic [3:0] C_OP_OR  = 4'h5;
    localparam logic [3:0] C_OP_XOR = 4'h6;
    localparam logic [3:0] C_OP_MOV = 4'h7;
    localparam logic [3:0] C_OP_LDR = 4'h8;
    localparam logic [3:0] C_OP_JMP = 4'h9;
    localparam logic [3:0] C_OP_JZ  = 4'hA;
    localparam logic [3:0] C_OP_JC  = 4'hB;
    localparam logic [3:0] C_OP_OUT = 4'hC;
    localparam logic [3:0] C_OP_HLT = 4'hD;
    localparam logic [3:0] C_OP_SHL = 4'hE;
    localparam logic [3:0] C_OP_SHR = 4'hF;

    typedef enum logic [1:0] {
        S_STOP   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_EXEC   = 2'd3
    } state_t;

    state_t              r_state;
    logic [INSTR_W-1:0]  r_mem [0:DEPTH-1];
    logic [INSTR_W-1:0]  r_ir;
    logic [DATA_W-1:0]   r_regs [0:NREG-1];
    logic [DATA_W-1:0]   r_opnd;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_acc;
    logic                r_z;
    logic                r_c;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;

    logic [3:0]          w_op;
    logic [RSEL_W-1:0]   w_rsel;
    logic [DATA_W-1:0]   w_imm;
    logic                w_rsel_ok;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_res;
    logic                w_acc_we;
    logic                w_c_next;
    logic                w_reg_we;
    logic                w_jump;
    logic                w_out;
    logic                w_halt;
    logic [ADDR_W-1:0]   w_jtarget;
    logic                w_go;
    logic                w_stop_after;

    assign w_op      = r_ir[INSTR_W-1 -: 4];
    assign w_rsel    = r_ir[DATA_W +: RSEL_W];
    assign w_imm     = r_ir[DATA_W-1:0];
    assign w_rsel_ok = ({1'b0, w_rsel} < C_NREG);
    assign w_jtarget = ADDR_W'(w_imm);

    // Extra top bit carries out of ADD; for SUB it is set exactly on borrow.
    assign w_sum  = {1'b0, r_acc} + {1'b0, r_opnd};
    assign w_diff = {1'b0, r_acc} - {1'b0, r_opnd};

`ifdef PROCESOR_STEP_EN
    // Remembers that the current run was launched by step, so it stops
    // after one instruction even if step_mode has since dropped.
    logic r_single;
    assign w_go         = start | step;
    assign w_stop_after = step_mode | r_single;
`else
    assign w_go         = start;
    assign w_stop_after = 1'b0;
`endif

    // Execute-stage result selection
    always_comb begin
        w_res    = r_acc;
        w_acc_we = 1'b0;
        w_c_next = r_c;
        w_reg_we = 1'b0;
        w_jump   = 1'b0;
        w_out    = 1'b0;
        w_halt   = 1'b0;
        case (w_op)
            C_OP_LDI: begin w_res = w_imm; w_acc_we = 1'b1; end
            C_OP_ADD: begin {w_c_next, w_res} = w_sum;  w_acc_we = 1'b1; end
            C_OP_SUB: begin {w_c_next, w_res} = w_diff; w_acc_we = 1'b1; end
            C_OP_AND: begin w_res = r_acc & r_opnd; w_acc_we = 1'b1; end
            C_OP_OR:  begin w_res = r_acc | r_opnd; w_acc_we = 1'b1; end
            C_OP_XOR: begin w_res = r_acc ^ r_opnd; w_acc_we = 1'b1; end
            C_OP_MOV: w_reg_we = 1'b1;
            C_OP_LDR: begin w_res = r_opnd; w_acc_we = 1'b1; end
            C_OP_JMP: w_jump = 1'b1;
            C_OP_JZ:  w_jump = r_z;
            C_OP_JC:  w_jump = r_c;
            C_OP_OUT: w_out = 1'b1;
            C_OP_HLT: w_halt = 1'b1;
            C_OP_SHL: begin
                w_res    = {r_acc[DATA_W-2:0], 1'b0};
                w_c_next = r_acc[DATA_W-1];
                w_acc_we = 1'b1;
            end
            C_OP_SHR: begin
                w_res    = {1'b0, r_acc[DATA_W-1:1]};
                w_c_next = r_acc[0];
                w_acc_we = 1'b1;
            end
            default: ; // NOP
        endcase
    end

    // Program memory is deliberately outside the reset domain so a reset
    // never destroys the loaded program.
    always_ff @(posedge clk) begin
        if (prog_we && (r_state == S_STOP)) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_STOP;
            r_ir        <= '0;
            r_opnd      <= '0;
            r_pc        <= '0;
            r_acc       <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
`ifdef PROCESOR_STEP_EN
            r_single    <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_STOP: begin
                    if (w_go) begin
                        r_state <= S_FETCH;
`ifdef PROCESOR_STEP_EN
                        r_single <= step & ~start;
`endif
                    end
                end
                S_FETCH: begin
                    r_ir    <= r_mem[r_pc];
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_opnd  <= w_rsel_ok ? r_regs[w_rsel] : '0;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_acc_we) begin
                        r_acc <= w_res;
                        r_z   <= (w_res == '0);
                    end
                    r_c <= w_c_next;
                    if (w_reg_we && w_rsel_ok) begin
                        r_regs[w_rsel] <= r_acc;
                    end
                    if (w_out) begin
                        r_out_data  <= r_acc;
                        r_out_valid <= 1'b1;
                    end
                    if (w_halt) begin
                        // pc stays on the HLT so a restart halts again
                        r_state <= S_STOP;
                    end else begin
                        r_pc    <= w_jump ? w_jtarget : r_pc + 1'b1;
                        r_state <= w_stop_after ? S_STOP : S_FETCH;
                    end
                end
                default: r_state <= S_STOP;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign pc        = r_pc;
    assign acc       = r_acc;
    assign flag_z    = r_z;
    assign flag_c    = r_c;
    assign halted    = (r_state == S_STOP);

endmodule
`default_nettype wire
